// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for up to 8 display positions.
// Walks the decoder select through slots of P_DIV clocks, blanking the first P_BLANK of each.
module led_scan_ctrl #(
    parameter int P_DIV   = 50000,
    parameter int P_BLANK = 16,
    parameter int P_NUM   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [31:0] i_data,
    input  logic        i_polarity,
    output logic [2:0]  o_sel,
    output logic        o_opt,
    output logic [3:0]  o_nibble,
    output logic        o_blank,
    output logic        o_frame,
    output logic [1:0]  o_state
);

    localparam int CW = (P_DIV > 1) ? $clog2(P_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(P_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(P_BLANK - 1);
    localparam logic [2:0]    SEL_LAST   = 3'(P_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    sel, sel_nx;
    logic [2:0]    sel_inc;
    logic          opt, opt_nx;
    logic [3:0]    nibble, nibble_nx;
    logic          frame, frame_nx;
    logic [31:0]   shadow, shadow_nx;

    assign sel_inc = sel + 3'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= '0;
            opt    <= 1'b0;
            nibble <= '0;
            frame  <= 1'b0;
            shadow <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sel    <= sel_nx;
            opt    <= opt_nx;
            nibble <= nibble_nx;
            frame  <= frame_nx;
            shadow <= shadow_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sel_nx    = sel;
        opt_nx    = opt;
        nibble_nx = nibble;
        frame_nx  = 1'b0;
        shadow_nx = shadow;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                sel_nx = '0;
                if (i_en) begin
                    state_nx  = BLANK;
                    shadow_nx = i_data;
                    opt_nx    = i_polarity;
                    nibble_nx = i_data[3:0];
                    frame_nx  = 1'b1;
                end
            end
            BLANK: begin
                if (!i_en) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    sel_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_nx = SHOW;
                end
            end
            SHOW: begin
                if (!i_en) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    sel_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = BLANK;
                    // Wrapping past the last position starts a new frame from fresh inputs.
                    if (sel == SEL_LAST) begin
                        sel_nx    = '0;
                        shadow_nx = i_data;
                        opt_nx    = i_polarity;
                        nibble_nx = i_data[3:0];
                        frame_nx  = 1'b1;
                    end else begin
                        sel_nx    = sel_inc;
                        nibble_nx = shadow[{sel_inc, 2'b00} +: 4];
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                sel_nx   = '0;
            end
        endcase
    end

    assign o_sel    = sel;
    assign o_opt    = opt;
    assign o_nibble = nibble;
    assign o_blank  = (state != SHOW);
    assign o_frame  = frame;
    assign o_state  = state;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: three instances cover the 8-, 3- and 1-position configurations.
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_led_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, en_b, en_c;
    logic [31:0] data;
    logic        pol;

    logic [2:0] sel_a, sel_b, sel_c;
    logic       opt_a, opt_b, opt_c;
    logic [3:0] nib_a, nib_b, nib_c;
    logic       blank_a, blank_b, blank_c;
    logic       frame_a, frame_b, frame_c;
    logic [1:0] st_a, st_b, st_c;

    int n_cmp = 0;
    int n_err = 0;

    led_scan_ctrl #(.P_DIV(8), .P_BLANK(2), .P_NUM(8)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_data(data), .i_polarity(pol),
        .o_sel(sel_a), .o_opt(opt_a), .o_nibble(nib_a), .o_blank(blank_a),
        .o_frame(frame_a), .o_state(st_a)
    );

    led_scan_ctrl #(.P_DIV(8), .P_BLANK(2), .P_NUM(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_data(data), .i_polarity(pol),
        .o_sel(sel_b), .o_opt(opt_b), .o_nibble(nib_b), .o_blank(blank_b),
        .o_frame(frame_b), .o_state(st_b)
    );

    led_scan_ctrl #(.P_DIV(4), .P_BLANK(1), .P_NUM(1)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_c), .i_data(data), .i_polarity(pol),
        .o_sel(sel_c), .o_opt(opt_c), .o_nibble(nib_c), .o_blank(blank_c),
        .o_frame(frame_c), .o_state(st_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int guard;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        data = 32'h0; pol = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        data = 32'h76543210; pol = 1'b1; en_a = 1'b1;
        guard = 0;
        while (!(sel_a == 3'd5 && blank_a == 1'b0) && guard < 200) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (!(sel_a == 3'd5 && blank_a == 1'b0)) begin
            n_err++;
            $display("FAIL reset_reach_sel5: sel=%0d blank=%0b, required sel=5 blank=0", sel_a, blank_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sel_a !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d required 0", sel_a); end
        n_cmp++;
        if (blank_a !== 1'b1) begin n_err++; $display("FAIL reset_blank: got %0b required 1", blank_a); end
        n_cmp++;
        if (nib_a !== 4'h0) begin n_err++; $display("FAIL reset_nibble: got %h required 0", nib_a); end
        n_cmp++;
        if (opt_a !== 1'b0) begin n_err++; $display("FAIL reset_opt: got %0b required 0", opt_a); end
        n_cmp++;
        if (frame_a !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %0b required 0", frame_a); end
        en_a = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (sel_a !== 3'd0 || blank_a !== 1'b1 || frame_a !== 1'b0 || opt_a !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: sel=%0d blank=%0b frame=%0b opt=%0b, required 0/1/0/0",
                     sel_a, blank_a, frame_a, opt_a);
        end
        n_cmp++;
        if (blank_b !== 1'b1 || blank_c !== 1'b1 || frame_b !== 1'b0 || frame_c !== 1'b0) begin
            n_err++;
            $display("FAIL idle_others: blank_b=%0b blank_c=%0b frame_b=%0b frame_c=%0b, required 1/1/0/0",
                     blank_b, blank_c, frame_b, frame_c);
        end
    endtask

    task automatic test_basic_scan();
        logic [2:0] exp_sel;
        logic       exp_blank;
        logic       exp_frame;
        data = 32'h76543210; pol = 1'b1; en_a = 1'b1;
        tick();
        for (int t = 0; t <= 64; t++) begin
            exp_sel   = 3'((t / 8) % 8);
            exp_blank = ((t % 8) < 2);
            exp_frame = ((t % 64) == 0);
            n_cmp++;
            if (sel_a !== exp_sel) begin n_err++; $display("FAIL scan_sel t=%0d: got %0d required %0d", t, sel_a, exp_sel); end
            n_cmp++;
            if (nib_a !== {1'b0, exp_sel}) begin n_err++; $display("FAIL scan_nibble t=%0d: got %h required %h", t, nib_a, exp_sel); end
            n_cmp++;
            if (blank_a !== exp_blank) begin n_err++; $display("FAIL scan_blank t=%0d: got %0b required %0b", t, blank_a, exp_blank); end
            n_cmp++;
            if (frame_a !== exp_frame) begin n_err++; $display("FAIL scan_frame t=%0d: got %0b required %0b", t, frame_a, exp_frame); end
            n_cmp++;
            if (opt_a !== 1'b1) begin n_err++; $display("FAIL scan_opt t=%0d: got %0b required 1", t, opt_a); end
            if (t < 64) tick();
        end
    endtask

    task automatic test_mid_frame();
        int guard;
        logic [2:0] exp_sel;
        guard = 0;
        while (sel_a != 3'd3 && guard < 100) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (sel_a !== 3'd3) begin n_err++; $display("FAIL mid_reach_sel3: got %0d required 3", sel_a); end
        data = 32'hFEDCBA98; pol = 1'b0;
        for (int i = 1; i < 40; i++) begin
            tick();
            exp_sel = 3'(3 + i / 8);
            n_cmp++;
            if (sel_a !== exp_sel || nib_a !== {1'b0, exp_sel} || opt_a !== 1'b1 || frame_a !== 1'b0) begin
                n_err++;
                $display("FAIL mid_old_frame i=%0d: sel=%0d nib=%h opt=%0b frame=%0b, required sel=%0d nib=%0d opt=1 frame=0",
                         i, sel_a, nib_a, opt_a, frame_a, exp_sel, exp_sel);
            end
        end
        tick();
        n_cmp++;
        if (sel_a !== 3'd0) begin n_err++; $display("FAIL mid_new_sel: got %0d required 0", sel_a); end
        n_cmp++;
        if (nib_a !== 4'h8) begin n_err++; $display("FAIL mid_new_nibble: got %h required 8", nib_a); end
        n_cmp++;
        if (opt_a !== 1'b0) begin n_err++; $display("FAIL mid_new_opt: got %0b required 0", opt_a); end
        n_cmp++;
        if (frame_a !== 1'b1) begin n_err++; $display("FAIL mid_new_frame: got %0b required 1", frame_a); end
        repeat (8) tick();
        n_cmp++;
        if (sel_a !== 3'd1 || nib_a !== 4'h9) begin
            n_err++;
            $display("FAIL mid_new_slot1: sel=%0d nib=%h, required sel=1 nib=9", sel_a, nib_a);
        end
    endtask

    task automatic test_disable();
        int guard;
        guard = 0;
        while (sel_a != 3'd2 && guard < 100) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        n_cmp++;
        if (sel_a !== 3'd2 || blank_a !== 1'b0) begin
            n_err++;
            $display("FAIL dis_setup: sel=%0d blank=%0b, required sel=2 blank=0", sel_a, blank_a);
        end
        en_a = 1'b0;
        tick();
        n_cmp++;
        if (blank_a !== 1'b1) begin n_err++; $display("FAIL dis_blank: got %0b required 1", blank_a); end
        n_cmp++;
        if (sel_a !== 3'd0) begin n_err++; $display("FAIL dis_sel: got %0d required 0", sel_a); end
        n_cmp++;
        if (frame_a !== 1'b0) begin n_err++; $display("FAIL dis_frame: got %0b required 0", frame_a); end
        n_cmp++;
        if (st_a !== 2'd0) begin n_err++; $display("FAIL dis_state: got %0d required 0", st_a); end
        n_cmp++;
        if (nib_a !== 4'hA || opt_a !== 1'b0) begin
            n_err++;
            $display("FAIL dis_hold: nib=%h opt=%0b, required nib=a opt=0", nib_a, opt_a);
        end
        tick();
        n_cmp++;
        if (blank_a !== 1'b1 || sel_a !== 3'd0 || frame_a !== 1'b0) begin
            n_err++;
            $display("FAIL dis_stay_idle: blank=%0b sel=%0d frame=%0b, required 1/0/0", blank_a, sel_a, frame_a);
        end
        data = 32'h0000000A; pol = 1'b1; en_a = 1'b1;
        tick();
        n_cmp++;
        if (frame_a !== 1'b1) begin n_err++; $display("FAIL reen_frame: got %0b required 1", frame_a); end
        n_cmp++;
        if (sel_a !== 3'd0 || nib_a !== 4'hA) begin
            n_err++;
            $display("FAIL reen_slot0: sel=%0d nib=%h, required sel=0 nib=a", sel_a, nib_a);
        end
        n_cmp++;
        if (opt_a !== 1'b1 || blank_a !== 1'b1) begin
            n_err++;
            $display("FAIL reen_opt_blank: opt=%0b blank=%0b, required 1/1", opt_a, blank_a);
        end
        repeat (8) tick();
        n_cmp++;
        if (sel_a !== 3'd1 || nib_a !== 4'h0 || frame_a !== 1'b0) begin
            n_err++;
            $display("FAIL reen_slot1: sel=%0d nib=%h frame=%0b, required 1/0/0", sel_a, nib_a, frame_a);
        end
        en_a = 1'b0;
        tick();
    endtask

    task automatic test_reduced_count();
        logic [2:0] exp_sel;
        logic       exp_blank;
        logic       exp_frame;
        data = 32'h76543210; pol = 1'b1; en_b = 1'b1;
        tick();
        for (int t = 0; t <= 48; t++) begin
            exp_sel   = 3'((t / 8) % 3);
            exp_blank = ((t % 8) < 2);
            exp_frame = ((t % 24) == 0);
            n_cmp++;
            if (sel_b !== exp_sel || nib_b !== {1'b0, exp_sel}) begin
                n_err++;
                $display("FAIL p3_sel t=%0d: sel=%0d nib=%h, required %0d", t, sel_b, nib_b, exp_sel);
            end
            n_cmp++;
            if (blank_b !== exp_blank || frame_b !== exp_frame) begin
                n_err++;
                $display("FAIL p3_blank_frame t=%0d: blank=%0b frame=%0b, required %0b/%0b",
                         t, blank_b, frame_b, exp_blank, exp_frame);
            end
            if (t < 48) tick();
        end
        en_b = 1'b0;
        tick();
    endtask

    task automatic test_degenerate();
        logic [3:0] vals [5] = '{4'h3, 4'hC, 4'h5, 4'hF, 4'h1};
        logic       exp_edge;
        data = {28'h1234567, vals[0]}; pol = 1'b0; en_c = 1'b1;
        tick();
        for (int t = 0; t < 20; t++) begin
            exp_edge = ((t % 4) == 0);
            n_cmp++;
            if (sel_c !== 3'd0) begin n_err++; $display("FAIL p1_sel t=%0d: got %0d required 0", t, sel_c); end
            n_cmp++;
            if (blank_c !== exp_edge || frame_c !== exp_edge) begin
                n_err++;
                $display("FAIL p1_blank_frame t=%0d: blank=%0b frame=%0b, required %0b/%0b",
                         t, blank_c, frame_c, exp_edge, exp_edge);
            end
            n_cmp++;
            if (nib_c !== vals[t / 4]) begin
                n_err++;
                $display("FAIL p1_nibble t=%0d: got %h required %h", t, nib_c, vals[t / 4]);
            end
            if ((t % 4) == 1 && (t / 4) < 4) data[3:0] = vals[t / 4 + 1];
            if (t < 19) tick();
        end
        en_c = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_scan();
        test_mid_frame();
        test_disable();
        test_reduced_count();
        test_degenerate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
